// File: rtl/spi_byte_master.sv
`default_nettype none
// ============================================================================
// Module : spi_byte_master
// Brief  : Mode-0 SPI byte master with valid/ready byte streams and SS framing.
// Rev    : 1.0  initial release
// ============================================================================
module spi_byte_master #(
    parameter int unsigned DIV = 4
) (
    input  logic       io_clock,
    input  logic       io_sysReset_n,
    input  logic       io_tx_valid,
    output logic       io_tx_ready,
    input  logic [7:0] io_tx_data,
    input  logic       io_tx_last,
    output logic       io_rx_valid,
    output logic [7:0] io_rx_data,
    input  logic       io_rx_ready,
    output logic       io_rx_overrun,
    input  logic       io_rx_overrun_clr,
    output logic       io_busy,
    output logic       io_spi0_sclk,
    output logic       io_spi0_ss,
    output logic       io_spi0_mosi,
    input  logic       io_spi0_miso
);
    localparam logic [7:0] C_LOAD = 8'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_GAP   = 3'd4,
        S_SSOFF = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic       r_mosi;
    logic       r_last;
    logic       r_armed;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_overrun;

    logic       w_accept;
    logic       w_cnt_zero;
    logic       w_sample;
    logic       w_high_end;
    logic       w_low_end;
    logic       w_byte_done;
    logic [7:0] w_sh_nxt;

    // r_armed keeps tx_ready low until the first clock after reset release
    assign io_tx_ready = ((r_state == S_IDLE) && r_armed) || (r_state == S_GAP);
    assign w_accept    = io_tx_valid && io_tx_ready;
    assign w_cnt_zero  = (r_cnt == 8'd0);
    assign w_sample    = (r_state == S_HIGH) && (r_cnt == C_LOAD);
    assign w_high_end  = (r_state == S_HIGH) && w_cnt_zero;
    assign w_low_end   = (r_state == S_LOW) && w_cnt_zero;
    assign w_byte_done = w_high_end && (r_bit == 3'd7);
    assign w_sh_nxt    = w_sample ? {r_sh[6:0], io_spi0_miso} : r_sh;

    assign io_spi0_sclk  = (r_state == S_HIGH);
    assign io_spi0_ss    = (r_state == S_IDLE) || (r_state == S_SSOFF);
    assign io_spi0_mosi  = r_mosi;
    assign io_busy       = (r_state != S_IDLE);
    assign io_rx_valid   = r_rx_valid;
    assign io_rx_data    = r_rx_data;
    assign io_rx_overrun = r_overrun;

    always_ff @(posedge io_clock or negedge io_sysReset_n) begin
        if (!io_sysReset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_LEAD;
            S_GAP:   if (w_accept) w_state_nxt = S_LEAD;
            S_LEAD:  if (w_cnt_zero) w_state_nxt = S_HIGH;
            S_HIGH:  if (w_cnt_zero) w_state_nxt = S_LOW;
            S_LOW: begin
                if (w_cnt_zero) begin
                    if (r_bit != 3'd7)  w_state_nxt = S_HIGH;
                    else if (r_last)    w_state_nxt = S_SSOFF;
                    else                w_state_nxt = S_GAP;
                end
            end
            S_SSOFF: if (w_cnt_zero) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Every transition changes state, so a state change reloads the phase timer
    always_ff @(posedge io_clock or negedge io_sysReset_n) begin
        if (!io_sysReset_n) begin
            r_cnt   <= 8'd0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_state_nxt != r_state) begin
                r_cnt <= C_LOAD;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge io_clock or negedge io_sysReset_n) begin
        if (!io_sysReset_n) begin
            r_sh   <= 8'd0;
            r_mosi <= 1'b0;
            r_last <= 1'b0;
            r_bit  <= 3'd0;
        end else if (w_accept) begin
            r_sh   <= io_tx_data;
            r_mosi <= io_tx_data[7];
            r_last <= io_tx_last;
            r_bit  <= 3'd0;
        end else begin
            r_sh <= w_sh_nxt;
            // next bit appears with the falling SCLK edge; MOSI holds after bit 0
            if (w_high_end && (r_bit != 3'd7)) begin
                r_mosi <= w_sh_nxt[7];
            end
            if (w_low_end) begin
                r_bit <= r_bit + 3'd1;
            end
        end
    end

    always_ff @(posedge io_clock or negedge io_sysReset_n) begin
        if (!io_sysReset_n) begin
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_byte_done) begin
                r_rx_data  <= w_sh_nxt;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && io_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (w_byte_done && r_rx_valid && !io_rx_ready) begin
                r_overrun <= 1'b1;
            end else if (io_rx_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
